duty_button_conditioner: RTL and testbench

//   Front-end conditioner for the PWM duty-cycle control buttons. Synchronises two raw push-button

---
 rtl/duty_btn_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/duty_button_conditioner.sv | 133 +++++++++++++
 tb/tb_duty_button_conditioner.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_btn_pkg.sv
// Shared definitions for the duty-cycle button conditioner.
// Contents:
//   DEF_*        default timing constants: debounce length, repeat delay,
//                repeat rate and counter width
//   rpt_state_e  encoding of the per-channel hold-to-repeat FSM
//                (ST_IDLE = 0, ST_HOLD = 1, ST_RPT = 2)
package duty_btn_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_RATE     = 8;
    localparam int DEF_CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: a 2-FF synchroniser followed by a debounce counter.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_raw_i    raw button input, asynchronous to clk
//   level_o      debounced level (registered)
//   level_next_o value level_o takes at the coming edge. It is derived only
//                from registers, so it carries no combinational path from
//                btn_raw_i. The top uses it so that command pulses register
//                on the same edge as the level change.
module btn_debounce
    import duty_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic level_next_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // level. Any cycle of agreement restarts it, so short glitches are
    // absorbed. It clears again when the level flips.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/duty_button_conditioner.sv
// Conditions the PWM duty-cycle increase/decrease buttons into clean
// single-cycle command pulses, with hold-to-repeat and conflict suppression.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   btn_inc_raw, btn_dec_raw    raw active-high buttons, asynchronous to clk
//   increase_duty/decrease_duty registered one-cycle command pulses
//   inc_level/dec_level         debounced button levels
// Channel index 0 is increase and channel index 1 is decrease.
// The pulse outputs behave as a valid-only stream. Each high cycle is one
// command. There is no ready signal, so the downstream block must accept a
// pulse in the cycle it appears.
module duty_button_conditioner
    import duty_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic increase_duty,
    output logic decrease_duty,
    output logic inc_level,
    output logic dec_level
);

    localparam bit               RPT_EN     = (REPEAT_DELAY != 0);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [1:0]       level;
    logic [1:0]       level_next;
    logic             hold_clear;
    rpt_state_e       state_q [2];
    rpt_state_e       state_d [2];
    logic [CNT_W-1:0] rcnt_q  [2];
    logic [CNT_W-1:0] rcnt_d  [2];
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_inc (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw_i    (btn_inc_raw),
        .level_o      (level[0]),
        .level_next_o (level_next[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_dec (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw_i    (btn_dec_raw),
        .level_o      (level[1]),
        .level_next_o (level_next[1])
    );

    // Both FSMs are pinned at HOLD with rcnt = 0 while both levels are high.
    // They are also pinned on the edge where the conflict ends. The surviving
    // channel then restarts its delay from that edge, the same way a fresh
    // press does.
    assign hold_clear = (&level_next) | (&level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= ST_IDLE;
                rcnt_q[ch]  <= '0;
            end
            pulse_q <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                rcnt_q[ch]  <= rcnt_d[ch];
            end
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            rcnt_d[ch]  = rcnt_q[ch];
            pulse_d[ch] = 1'b0;
            if (!level_next[ch]) begin
                state_d[ch] = ST_IDLE;
                rcnt_d[ch]  = '0;
            end else if (hold_clear) begin
                state_d[ch] = ST_HOLD;
                rcnt_d[ch]  = '0;
            end else begin
                unique case (state_q[ch])
                    ST_IDLE: begin
                        state_d[ch] = ST_HOLD;
                        rcnt_d[ch]  = '0;
                        pulse_d[ch] = 1'b1;
                    end
                    ST_HOLD: begin
                        if (!RPT_EN) begin
                            rcnt_d[ch] = '0;
                        end else if (rcnt_q[ch] == DELAY_LAST) begin
                            state_d[ch] = ST_RPT;
                            rcnt_d[ch]  = '0;
                            pulse_d[ch] = 1'b1;
                        end else begin
                            rcnt_d[ch] = rcnt_q[ch] + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (rcnt_q[ch] == RATE_LAST) begin
                            rcnt_d[ch]  = '0;
                            pulse_d[ch] = 1'b1;
                        end else begin
                            rcnt_d[ch] = rcnt_q[ch] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[ch] = ST_IDLE;
                        rcnt_d[ch]  = '0;
                    end
                endcase
            end
        end
    end

    assign increase_duty = pulse_q[0];
    assign decrease_duty = pulse_q[1];
    assign inc_level     = level[0];
    assign dec_level     = level[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Bench for duty_button_conditioner. Edge numbers count rising clock edges.
// Expected pulse edges are queued when a press is driven. The monitor
// collects observed pulse edges, and each scenario task compares the two.
module tb_duty_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_inc_raw;
    logic btn_dec_raw;
    logic increase_duty;
    logic decrease_duty;
    logic inc_level;
    logic dec_level;

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int both_hi_cnt = 0;

    logic [31:0] exp_inc_q[$];
    logic [31:0] exp_dec_q[$];
    logic [31:0] obs_inc_q[$];
    logic [31:0] obs_dec_q[$];

    duty_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (16),
        .REPEAT_RATE     (8),
        .CNT_W           (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_inc_raw   (btn_inc_raw),
        .btn_dec_raw   (btn_dec_raw),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .inc_level     (inc_level),
        .dec_level     (dec_level)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record the edge number of every pulse
    always @(negedge clk) begin
        if (increase_duty === 1'b1) obs_inc_q.push_back(32'(cyc));
        if (decrease_duty === 1'b1) obs_dec_q.push_back(32'(cyc));
        if (increase_duty === 1'b1 && decrease_duty === 1'b1) both_hi_cnt++;
    end

    task automatic idle_gap();
        repeat ($urandom_range(3, 10)) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({increase_duty, decrease_duty, inc_level, dec_level} === 4'b0000) n_pass++;
        else $display("FAIL reset_hold: got %b, expected 0000",
                      {increase_duty, decrease_duty, inc_level, dec_level});
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({increase_duty, decrease_duty, inc_level, dec_level} === 4'b0000) n_pass++;
        else $display("FAIL reset_first_edge: got %b, expected 0000",
                      {increase_duty, decrease_duty, inc_level, dec_level});
        repeat (50) begin
            @(negedge clk);
            if ({increase_duty, decrease_duty, inc_level, dec_level} !== 4'b0000) bad++;
        end
        n_checks++;
        if (bad == 0) n_pass++;
        else $display("FAIL reset_quiet: got %0d active cycles, expected 0", bad);
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    task automatic test_clean_press();
        int k;
        logic [31:0] e, o;
        idle_gap();
        k = cyc + 1;
        btn_inc_raw = 1'b1;
        exp_inc_q.push_back(32'(k + 5));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cyc == k + 4) begin
                n_checks++;
                if (inc_level === 1'b0) n_pass++;
                else $display("FAIL press_level_early: got %b, expected 0", inc_level);
            end
            if (cyc == k + 5) begin
                n_checks++;
                if (inc_level === 1'b1) n_pass++;
                else $display("FAIL press_level_rise: got %b, expected 1", inc_level);
            end
        end
        btn_inc_raw = 1'b0;
        repeat (25) @(negedge clk);
        n_checks++;
        if (inc_level === 1'b0) n_pass++;
        else $display("FAIL press_level_fall: got %b, expected 0", inc_level);
        n_checks++;
        if (obs_dec_q.size() == 0) n_pass++;
        else $display("FAIL press_dec_quiet: got %0d dec pulses, expected 0", obs_dec_q.size());
        n_checks++;
        if (obs_inc_q.size() == exp_inc_q.size()) n_pass++;
        else $display("FAIL press_inc_count: got %0d, expected %0d", obs_inc_q.size(), exp_inc_q.size());
        while (exp_inc_q.size() > 0) begin
            e = exp_inc_q.pop_front();
            o = 32'hFFFF_FFFF;
            if (obs_inc_q.size() > 0) o = obs_inc_q.pop_front();
            n_checks++;
            if (o === e) n_pass++;
            else $display("FAIL press_inc_edge: got %0d, expected %0d", o, e);
        end
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    task automatic test_glitch();
        int bad = 0;
        idle_gap();
        btn_dec_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_dec_raw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dec_level !== 1'b0) bad++;
        end
        n_checks++;
        if (bad == 0) n_pass++;
        else $display("FAIL glitch_level: got %0d cycles high, expected 0", bad);
        n_checks++;
        if (obs_dec_q.size() == 0) n_pass++;
        else $display("FAIL glitch_pulse: got %0d dec pulses, expected 0", obs_dec_q.size());
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    task automatic test_hold();
        int k, p, fall, t;
        logic [31:0] e, o;
        idle_gap();
        k = cyc + 1;
        btn_inc_raw = 1'b1;
        p = k + 5;
        fall = p + 50;
        exp_inc_q.push_back(32'(p));
        for (t = p + 16; t < fall; t += 8) exp_inc_q.push_back(32'(t));
        repeat (50) @(negedge clk);
        btn_inc_raw = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (obs_inc_q.size() == exp_inc_q.size()) n_pass++;
        else $display("FAIL hold_inc_count: got %0d, expected %0d", obs_inc_q.size(), exp_inc_q.size());
        while (exp_inc_q.size() > 0) begin
            e = exp_inc_q.pop_front();
            o = 32'hFFFF_FFFF;
            if (obs_inc_q.size() > 0) o = obs_inc_q.pop_front();
            n_checks++;
            if (o === e) n_pass++;
            else $display("FAIL hold_inc_edge: got %0d, expected %0d (rel %0d)", o, e, int'(e) - p);
        end
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    task automatic test_conflict();
        int j, f;
        logic [31:0] e, o;
        idle_gap();
        btn_inc_raw = 1'b1;
        btn_dec_raw = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if ({inc_level, dec_level} === 2'b11) n_pass++;
        else $display("FAIL conflict_levels: got %b, expected 11", {inc_level, dec_level});
        n_checks++;
        if (obs_inc_q.size() + obs_dec_q.size() == 0) n_pass++;
        else $display("FAIL conflict_quiet: got %0d pulses, expected 0", obs_inc_q.size() + obs_dec_q.size());
        btn_dec_raw = 1'b0;
        j = cyc + 1;
        f = j + 5;
        exp_inc_q.push_back(32'(f + 16));
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (cyc == f) begin
                n_checks++;
                if (dec_level === 1'b0) n_pass++;
                else $display("FAIL conflict_dec_fall: got %b, expected 0", dec_level);
            end
        end
        btn_inc_raw = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (obs_dec_q.size() == 0) n_pass++;
        else $display("FAIL conflict_dec_pulses: got %0d, expected 0", obs_dec_q.size());
        n_checks++;
        if (obs_inc_q.size() == exp_inc_q.size()) n_pass++;
        else $display("FAIL conflict_inc_count: got %0d, expected %0d", obs_inc_q.size(), exp_inc_q.size());
        while (exp_inc_q.size() > 0) begin
            e = exp_inc_q.pop_front();
            o = 32'hFFFF_FFFF;
            if (obs_inc_q.size() > 0) o = obs_inc_q.pop_front();
            n_checks++;
            if (o === e) n_pass++;
            else $display("FAIL conflict_inc_edge: got %0d, expected %0d", o, e);
        end
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    task automatic test_dec_hold();
        int k, len, p, fall, t;
        logic [31:0] e, o;
        idle_gap();
        len = $urandom_range(8, 60);
        k = cyc + 1;
        btn_dec_raw = 1'b1;
        p = k + 5;
        fall = k + len + 5;
        exp_dec_q.push_back(32'(p));
        for (t = p + 16; t < fall; t += 8) exp_dec_q.push_back(32'(t));
        repeat (len) @(negedge clk);
        btn_dec_raw = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (obs_inc_q.size() == 0) n_pass++;
        else $display("FAIL dec_hold_inc_quiet: got %0d, expected 0", obs_inc_q.size());
        n_checks++;
        if (obs_dec_q.size() == exp_dec_q.size()) n_pass++;
        else $display("FAIL dec_hold_count: got %0d, expected %0d (len %0d)", obs_dec_q.size(), exp_dec_q.size(), len);
        while (exp_dec_q.size() > 0) begin
            e = exp_dec_q.pop_front();
            o = 32'hFFFF_FFFF;
            if (obs_dec_q.size() > 0) o = obs_dec_q.pop_front();
            n_checks++;
            if (o === e) n_pass++;
            else $display("FAIL dec_hold_edge: got %0d, expected %0d", o, e);
        end
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    task automatic test_reset_mid_hold();
        int k, p, k2;
        logic [31:0] e, o;
        idle_gap();
        k = cyc + 1;
        btn_inc_raw = 1'b1;
        p = k + 5;
        exp_inc_q.push_back(32'(p));
        exp_inc_q.push_back(32'(p + 16));
        exp_inc_q.push_back(32'(p + 24));
        repeat (30) @(negedge clk);
        // cyc is now p + 24: the first RPT pulse is on the output
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({increase_duty, decrease_duty, inc_level, dec_level} === 4'b0000) n_pass++;
        else $display("FAIL mid_hold_async_clear: got %b, expected 0000",
                      {increase_duty, decrease_duty, inc_level, dec_level});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k2 = cyc + 1;
        exp_inc_q.push_back(32'(k2 + 5));
        exp_inc_q.push_back(32'(k2 + 21));
        exp_inc_q.push_back(32'(k2 + 29));
        repeat (31) @(negedge clk);
        btn_inc_raw = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (obs_inc_q.size() == exp_inc_q.size()) n_pass++;
        else $display("FAIL mid_hold_count: got %0d, expected %0d", obs_inc_q.size(), exp_inc_q.size());
        while (exp_inc_q.size() > 0) begin
            e = exp_inc_q.pop_front();
            o = 32'hFFFF_FFFF;
            if (obs_inc_q.size() > 0) o = obs_inc_q.pop_front();
            n_checks++;
            if (o === e) n_pass++;
            else $display("FAIL mid_hold_edge: got %0d, expected %0d", o, e);
        end
        obs_inc_q.delete();
        obs_dec_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_hold();
        test_conflict();
        test_dec_hold();
        test_reset_mid_hold();
        n_checks++;
        if (both_hi_cnt == 0) n_pass++;
        else $display("FAIL exclusive_pulses: got %0d overlapping cycles, expected 0", both_hi_cnt);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
